// File: rtl/inst_mem_loader_pkg.sv
// rtl/inst_mem_loader_pkg.sv - shared sizes, data type and loader state encoding
package inst_mem_loader_pkg;
  localparam int ADDR_SIZE      = 5;
  localparam int DATA_SIZE      = 32;
  localparam int MEM_LEN        = 32;
  localparam int BYTES_PER_WORD = DATA_SIZE / 8;
  localparam int CNT_SIZE       = ADDR_SIZE + 1;
  localparam int BIDX_SIZE      = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  typedef logic [DATA_SIZE-1:0] data_port;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CHK,
    DONE,
    ERR
  } loader_state_t;
endpackage

// File: rtl/inst_mem_loader_if.sv
// rtl/inst_mem_loader_if.sv - byte stream in, instruction-memory write port out
interface inst_mem_loader_if;
  import inst_mem_loader_pkg::*;

  logic                 byte_valid;
  logic [7:0]           byte_data;
  logic                 byte_ready;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  data_port             mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_mem_loader_byte_assembler.sv
// rtl/inst_mem_loader_byte_assembler.sv - packs accepted bytes little-endian into one word
module inst_mem_loader_byte_assembler
  import inst_mem_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       accept,
  input  logic [7:0] byte_data,
  output data_port   word_next,
  output logic       word_done
);
  localparam logic [BIDX_SIZE-1:0] LAST_IDX = BIDX_SIZE'(BYTES_PER_WORD - 1);

  logic [BIDX_SIZE-1:0] byte_idx;
  data_port             word_q;

  // word_next already includes the byte accepted this cycle, so the FSM can
  // register the complete word on the same edge as the last handshake
  always_comb begin
    word_next = word_q;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (accept && byte_idx == BIDX_SIZE'(k)) begin
        word_next[8*k +: 8] = byte_data;
      end
    end
  end

  assign word_done = accept && (byte_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx <= '0;
      word_q   <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (accept) begin
      word_q   <= word_next;
      byte_idx <= word_done ? '0 : byte_idx + BIDX_SIZE'(1);
    end
  end
endmodule

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - fills instruction memory from a byte stream, then raises load_done
// Optional trailing XOR checksum byte: INST_MEM_LOADER_CHECKSUM_EN.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_SIZE-1:0] word_count,
  inst_mem_loader_if.slave    bus,
  output logic                busy,
  output logic                load_done,
  output logic                error
);
  localparam logic [CNT_SIZE-1:0] MAX_COUNT = CNT_SIZE'(MEM_LEN);

  loader_state_t        state;
  logic [CNT_SIZE-1:0]  count;
  logic [ADDR_SIZE-1:0] word_idx;
  logic                 accept;
  logic                 recv_accept;
  logic                 start_ok;
  logic                 count_ok;
  logic                 last_word;
  logic                 word_done;
  data_port             word_next;

  assign accept      = bus.byte_valid && bus.byte_ready;
  assign recv_accept = accept && (state == RECV);
  assign start_ok    = start && (state == IDLE || state == DONE || state == ERR);
  assign count_ok    = (word_count != '0) && (word_count <= MAX_COUNT);
  assign last_word   = ({1'b0, word_idx} == count - CNT_SIZE'(1));

  inst_mem_loader_byte_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok),
    .accept    (recv_accept),
    .byte_data (bus.byte_data),
    .word_next (word_next),
    .word_done (word_done)
  );

`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q <= '0;
    end else if (start_ok) begin
      xor_q <= '0;
    end else if (recv_accept) begin
      xor_q <= xor_q ^ bus.byte_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      count          <= '0;
      word_idx       <= '0;
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      busy           <= 1'b0;
      load_done      <= 1'b0;
      error          <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            load_done <= 1'b0;
            if (count_ok) begin
              state          <= RECV;
              count          <= word_count;
              word_idx       <= '0;
              error          <= 1'b0;
              busy           <= 1'b1;
              bus.byte_ready <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        RECV: begin
          if (word_done) begin
            state          <= WRITE;
            bus.byte_ready <= 1'b0;
            bus.mem_we     <= 1'b1;
            bus.mem_addr   <= word_idx;
            bus.mem_wdata  <= word_next;
          end
        end
        WRITE: begin
          if (last_word) begin
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            state          <= CHK;
            bus.byte_ready <= 1'b1;
`else
            state     <= DONE;
            busy      <= 1'b0;
            load_done <= 1'b1;
`endif
          end else begin
            word_idx       <= word_idx + ADDR_SIZE'(1);
            state          <= RECV;
            bus.byte_ready <= 1'b1;
          end
        end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            bus.byte_ready <= 1'b0;
            busy           <= 1'b0;
            if (bus.byte_data == xor_q) begin
              state     <= DONE;
              load_done <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - directed self-checking bench for inst_mem_loader
`timescale 1ns/1ps
module tb_inst_mem_loader;
  import inst_mem_loader_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [CNT_SIZE-1:0] word_count = '0;
  logic                busy;
  logic                load_done;
  logic                error;

  inst_mem_loader_if bus();

  inst_mem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .bus        (bus),
    .busy       (busy),
    .load_done  (load_done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nwr = 0;
  int done_cyc = -1;
  int wr_cyc [0:63];
  logic [ADDR_SIZE-1:0] wr_addr [0:63];
  data_port wr_data [0:63];
  data_port mem_model [0:MEM_LEN-1];
  logic [7:0] stream [0:255];
  int hs_cyc [0:255];
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  bit ck_bad = 1'b0;
`endif

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_cyc[nwr]  = cyc;
      wr_addr[nwr] = bus.mem_addr;
      wr_data[nwr] = bus.mem_wdata;
      mem_model[bus.mem_addr] = bus.mem_wdata;
      if (nwr < 63) nwr++;
    end
    if (load_done && done_cyc < 0) done_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; byte_ready is registered so its value now is what the next posedge sees.
  task automatic send_byte(input int idx, input logic [7:0] b);
    bit ok = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int w = 0; w < 64 && !ok; w++) begin
      ok = bus.byte_ready;
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    if (!ok) chk("hs_timeout", ok, 1);
    hs_cyc[idx] = cyc;
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (busy) chk("idle_timeout", busy, 0);
    #1;
  endtask

  task automatic run_load(input int cnt, input int nbytes, input int gap_max);
    logic [7:0] x = 8'h00;
    nwr = 0;
    done_cyc = -1;
    start = 1'b1;
    word_count = CNT_SIZE'(cnt);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      send_byte(i, stream[i]);
      x ^= stream[i];
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    if (cnt > 0 && cnt <= MEM_LEN) send_byte(nbytes, ck_bad ? (x ^ 8'h01) : x);
`endif
    wait_idle();
  endtask

  task automatic load_two_word_stream();
    logic [7:0] s [0:7] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    for (int i = 0; i < 8; i++) stream[i] = s[i];
  endtask

  initial begin
    data_port exp_w;
    int nmis;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (2) @(negedge clk);

    chk("rst_byte_ready", bus.byte_ready, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_error", error, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // two words back-to-back
    load_two_word_stream();
    run_load(2, 8, 0);
    chk("t1_nwr", nwr, 2);
    chk("t1_addr0", wr_addr[0], 0);
    chk("t1_data0", wr_data[0], 32'h0010_0513);
    chk("t1_addr1", wr_addr[1], 1);
    chk("t1_data1", wr_data[1], 32'h0020_0593);
    chk("t1_lat0", wr_cyc[0], hs_cyc[3]);
    chk("t1_lat1", wr_cyc[1], hs_cyc[7]);
`ifndef INST_MEM_LOADER_CHECKSUM_EN
    chk("t1_done_lat", done_cyc, wr_cyc[1] + 1);
`endif
    chk("t1_load_done", load_done, 1);
    chk("t1_error", error, 0);
    chk("t1_hold_addr", bus.mem_addr, 1);
    chk("t1_hold_wdata", bus.mem_wdata, 32'h0020_0593);

    // bytes offered while DONE must not be taken
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hff;
    repeat (3) @(negedge clk);
    chk("done_ready", bus.byte_ready, 0);
    bus.byte_valid = 1'b0;
    chk("done_no_write", nwr, 2);

    // same stream with valid gaps
    run_load(2, 8, 3);
    chk("t2_nwr", nwr, 2);
    chk("t2_data0", wr_data[0], 32'h0010_0513);
    chk("t2_data1", wr_data[1], 32'h0020_0593);
    chk("t2_load_done", load_done, 1);

    // rejected counts
    run_load(0, 0, 0);
    chk("wc0_error", error, 1);
    chk("wc0_done", load_done, 0);
    chk("wc0_nwr", nwr, 0);
    run_load(33, 0, 0);
    chk("wc33_error", error, 1);
    chk("wc33_done", load_done, 0);
    chk("wc33_nwr", nwr, 0);

    // full memory
    for (int i = 0; i < 128; i++) stream[i] = 8'((i * 7 + 3) & 8'hff);
    run_load(32, 128, 0);
    chk("full_nwr", nwr, 32);
    chk("full_last_addr", wr_addr[31], 31);
    chk("full_error", error, 0);
    chk("full_load_done", load_done, 1);
    nmis = 0;
    for (int w = 0; w < 32; w++) begin
      exp_w = {stream[4*w+3], stream[4*w+2], stream[4*w+1], stream[4*w]};
      if (mem_model[w] !== exp_w) nmis++;
    end
    chk("full_words", nmis, 0);

    // reset in the middle of a load
    load_two_word_stream();
    start = 1'b1;
    word_count = CNT_SIZE'(2);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(i, stream[i]);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", bus.byte_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wdata", bus.mem_wdata, 0);
    chk("mid_rst_we", bus.mem_we, 0);
    chk("mid_rst_done", load_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stream[0] = 8'haa; stream[1] = 8'hbb; stream[2] = 8'hcc; stream[3] = 8'hdd;
    run_load(1, 4, 0);
    chk("after_rst_nwr", nwr, 1);
    chk("after_rst_addr", wr_addr[0], 0);
    chk("after_rst_data", wr_data[0], 32'hddcc_bbaa);
    chk("after_rst_done", load_done, 1);

    // start pulse while busy is ignored
    nwr = 0;
    start = 1'b1;
    word_count = CNT_SIZE'(1);
    @(negedge clk);
    start = 1'b0;
    send_byte(0, 8'h11);
    send_byte(1, 8'h22);
    start = 1'b1;
    word_count = CNT_SIZE'(3);
    @(negedge clk);
    start = 1'b0;
    send_byte(2, 8'h33);
    send_byte(3, 8'h44);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    send_byte(4, 8'h44);
`endif
    wait_idle();
    chk("busy_start_nwr", nwr, 1);
    chk("busy_start_data", wr_data[0], 32'h4433_2211);
    chk("busy_start_done", load_done, 1);

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    stream[0] = 8'h01; stream[1] = 8'h02; stream[2] = 8'h04; stream[3] = 8'h08;
    ck_bad = 1'b0;
    run_load(1, 4, 0);
    chk("ck_ok_done", load_done, 1);
    chk("ck_ok_error", error, 0);
    chk("ck_ok_data", wr_data[0], 32'h0804_0201);
    ck_bad = 1'b1;
    run_load(1, 4, 0);
    chk("ck_bad_error", error, 1);
    chk("ck_bad_done", load_done, 0);
    chk("ck_bad_mem", mem_model[0], 32'h0804_0201);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Write-side counterpart of the instruction memory: fills instruction memory before the processor fetches from it.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian DATA_SIZE-bit words.
- Writes those words to sequential instruction-memory addresses starting at 0.
- Raises load_done when finished; load_done gates the processor's run/enable.

Parameters:
- ADDR_SIZE, 5, instruction-memory address width (from package).
- DATA_SIZE, 32, instruction word width in bits; must be a multiple of 8.
- MEM_LEN, 32, instruction-memory depth in words (from package).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load; ignored while busy.
- word_count  in  ADDR_SIZE+1  number of words to load; latched on the accepted start.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader can accept a byte.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_SIZE  write address.
- mem_wdata  out  DATA_SIZE  write data (data_port type).
- busy  out  1  load in progress.
- load_done  out  1  load completed successfully; sticky.
- error  out  1  load rejected or failed; sticky.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0; byte and word counters 0; assembly register 0.
  - Memory contents are not touched.
  - Reset mid-load aborts the load immediately; recovery needs a new start.
- States: IDLE, RECV, WRITE, DONE, ERR. Outputs are registered or decoded from state only; no combinational path from byte_valid to byte_ready.
- IDLE/DONE/ERR + start:
  - If word_count==0 or word_count>MEM_LEN: go to ERR (error=1 next cycle, load_done=0).
  - Otherwise latch the count, clear the counters, clear load_done and error, and go to RECV.
- RECV:
  - byte_ready=1 and busy=1.
  - A byte is accepted when byte_valid && byte_ready.
  - The accepted byte is stored at bits [8*k+7:8*k], where k is the byte index (first byte is least significant).
  - On acceptance of byte DATA_SIZE/8-1, go to WRITE.
- WRITE (exactly one cycle):
  - byte_ready=0; mem_we=1; mem_addr=word index; mem_wdata=assembled word.
  - Latency: mem_we is asserted in the cycle after the last byte handshake.
  - If word index == count-1: go to DONE. Otherwise increment the word index, reset the byte index, and return to RECV.
- DONE: busy=0, load_done=1, byte_ready=0.
- ERR: busy=0, error=1, byte_ready=0.
- mem_we is 0 in every state except WRITE. mem_addr and mem_wdata hold their last value outside WRITE.
- start while busy is ignored; it has no effect on the counters or the latched count.
- byte_valid outside RECV is ignored (no byte is consumed).
- Gaps in byte_valid stall assembly indefinitely without loss of data.
- word_count==MEM_LEN writes addresses 0..MEM_LEN-1. The word index never wraps.

Optional Feature:
- Macro: INST_MEM_LOADER_CHECKSUM_EN.
- When defined:
  - A running XOR of all accepted payload bytes is kept.
  - After the final WRITE, the FSM enters CHK (byte_ready=1) and accepts one checksum byte.
  - If it equals the running XOR, go to DONE; otherwise go to ERR.
  - Words already written remain in memory.
- When undefined: no CHK state, no XOR register; the final WRITE goes directly to DONE.

Decomposition:
- The shared package already holds ADDR_SIZE, DATA_SIZE, MEM_LEN and data_port.
- Add to that package:
  - loader_state_t enum: IDLE, RECV, WRITE, CHK, DONE, ERR.
  - BYTES_PER_WORD = DATA_SIZE/8.
- One natural sub-module: byte_assembler. It holds the byte index, shift/insert logic and the word-complete flag. The FSM stays in inst_mem_loader.

Test Plan:
- Load 2 words:
  - Stimulus: word_count=2, bytes 13 05 10 00 93 05 20 00 with back-to-back valid.
  - Response: mem_we pulses at addr 0 data 0x00100513, then addr 1 data 0x00200593; load_done=1 one cycle after the second WRITE.
- Backpressure/gaps:
  - Stimulus: same stream with byte_valid deasserted for 3 random cycles between bytes.
  - Response: identical writes; mem_we count=2; no byte lost or duplicated.
- Bounds:
  - word_count=0 -> error=1, no mem_we.
  - word_count=33 -> error=1, no mem_we.
  - word_count=32 with 128 bytes -> last write at addr 31, load_done=1.
- Reset mid-load: rst_n low after 6 bytes -> all outputs 0 asynchronously; a new start with word_count=1 writes addr 0 with the next 4 bytes.
- start pulsed during RECV -> ignored; the latched count is unchanged; the original load completes normally.
- CHECKSUM_EN:
  - Stimulus: word_count=1, bytes 01 02 04 08.
  - Checksum 0x0F -> load_done=1.
  - Checksum 0x0E -> error=1, load_done=0; addr 0 still holds 0x08040201.
